// File: rtl/edge_period_meter_pkg.sv
// ---------------------------------------------------------------------------
// epm_pkg : shared definitions for the edge period meter.
//   state_t          - measurement FSM states
//   CNT_W_DEF        - default period counter width
//   SYNC_STAGES_DEF  - default synchronizer depth on sig_in
// ---------------------------------------------------------------------------
package epm_pkg;

   localparam int CNT_W_DEF       = 28;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

endpackage

// File: rtl/edge_period_meter_if.sv
// ---------------------------------------------------------------------------
// edge_period_meter_if : signal bundle between the meter and its user.
//   en           - measurement enable (user -> meter)
//   sig_in       - asynchronous signal to measure (user -> meter)
//   period       - last completed period in clk cycles (meter -> user)
//   period_valid - one-cycle pulse when period is updated (meter -> user)
//   timeout      - level, no edge seen for the full counter range
//
// Handshake: period_valid is a pure valid strobe with no ready/backpressure.
// It is high for exactly one clk cycle per completed measurement, and
// period is guaranteed stable in that cycle and held until the next pulse.
//
// Modports: master = user side (drives en/sig_in), slave = meter side.
// ---------------------------------------------------------------------------
interface edge_period_meter_if
   import epm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             timeout;

   modport master (output en, output sig_in,
                   input  period, input period_valid, input timeout);
   modport slave  (input  en, input sig_in,
                   output period, output period_valid, output timeout);
endinterface

// File: rtl/edge_period_meter_sync_rise_detect.sv
// ---------------------------------------------------------------------------
// sync_rise_detect : brings an asynchronous input into the clk domain and
// flags its rising edges.
//   clk, rst_n - system clock, asynchronous active-low reset
//   d          - asynchronous input
//   rise       - high for one cycle after a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module sync_rise_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   // Decoded from flops only, so the pulse is glitch-free and one cycle wide.
   assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/edge_period_meter.sv
// ---------------------------------------------------------------------------
// edge_period_meter : measures the spacing of rising edges on sig_in in clk
// cycles, publishing each period with a one-cycle valid pulse and raising a
// timeout level when no edge arrives within the counter range.
//   clk, rst_n - system clock, asynchronous active-low reset
//   bus        - slave side of edge_period_meter_if (en, sig_in in;
//                period, period_valid, timeout out)
//   dbg_state  - current FSM state, for observation only
// ---------------------------------------------------------------------------
module edge_period_meter
   import epm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   edge_period_meter_if.slave        bus,
   output state_t                    dbg_state
);

   // Last count value before the counter would overflow: 2^CNT_W - 2.
   // Reaching it without an edge means the period cannot be represented.
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

   logic             rise;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_q;
   logic             valid_q;
   logic             timeout_q;

   sync_rise_detect #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.sig_in),
      .rise  (rise)
   );

   // cnt holds (cycles since last edge) - 1, so a period of N cycles is
   // reported as cnt + 1 on the cycle the next edge is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         // Disable wins over a coincident edge; period is left untouched.
         if (!bus.en) begin
            state     <= IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // First edge only opens the measurement window.
                  if (rise) begin
                     state <= MEASURE;
                     cnt   <= '0;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     period_q <= cnt + CNT_W'(1);
                     valid_q  <= 1'b1;
                     cnt      <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state     <= TIMEOUT;
                     timeout_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               TIMEOUT: begin
                  // The interval that just ended was too long to report.
                  if (rise) begin
                     state     <= MEASURE;
                     cnt       <= '0;
                     timeout_q <= 1'b0;
                  end
               end
               default: begin
                  state     <= IDLE;
                  cnt       <= '0;
                  timeout_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.period       = period_q;
   assign bus.period_valid = valid_q;
   assign bus.timeout      = timeout_q;
   assign dbg_state        = state;

endmodule

// File: tb/tb_edge_period_meter.sv
// ---------------------------------------------------------------------------
// tb_edge_period_meter : drives two meters (CNT_W=28 and CNT_W=8) with the
// same sig_in/en stimulus. A reference model predicts pulses from the times
// at which edges become visible and the gap between them; a monitor pops
// predictions when the DUTs pulse and checks timeout/period every cycle.
// ---------------------------------------------------------------------------
module tb_edge_period_meter;
   import epm_pkg::*;

   localparam int SYNC = SYNC_STAGES_DEF;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic sig_drv = 1'b0;
   logic en_drv  = 1'b0;

   always #5 clk = ~clk;

   edge_period_meter_if #(.CNT_W(28)) bus_a ();
   edge_period_meter_if #(.CNT_W(8))  bus_b ();

   assign bus_a.en     = en_drv;
   assign bus_a.sig_in = sig_drv;
   assign bus_b.en     = en_drv;
   assign bus_b.sig_in = sig_drv;

   state_t dbg_a;
   state_t dbg_b;

   edge_period_meter #(.CNT_W(28), .SYNC_STAGES(SYNC)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_a),
      .dbg_state (dbg_a)
   );

   edge_period_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_b),
      .dbg_state (dbg_b)
   );

   // ---------------- bookkeeping ----------------
   int     checks = 0;
   int     fails  = 0;
   longint cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // An sig_in level sampled at posedge k is seen as an edge by the meter at
   // posedge k+SYNC. A rising edge is reported as the gap (in cycles) to the
   // previous accepted edge, if the meter was armed and the gap fits in CNT_W
   // bits. Timeout is up once the gap reaches 2^CNT_W-1 registering cycles
   // with no edge (2^CNT_W cycles after the edge was first visible).
   logic        hist[$];
   longint      maxp    [2];
   bit          armed   [2];
   longint      last_e  [2];
   longint      hold    [2];
   bit          exp_tmo [2];
   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];

   initial begin
      maxp[0] = (longint'(1) << 28) - 1;
      maxp[1] = (longint'(1) << 8) - 1;
      for (int d = 0; d < 2; d++) begin
         armed[d] = 0; last_e[d] = 0; hold[d] = 0; exp_tmo[d] = 0;
      end
   end

   always @(posedge clk) begin
      bit     rise_now;
      longint gap;
      cyc++;
      while (hist.size() < 8) hist.push_front(1'b0);
      hist.push_back(rst_n ? sig_drv : 1'b0);
      void'(hist.pop_front());
      rise_now = hist[hist.size()-1-SYNC] && !hist[hist.size()-2-SYNC];
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            armed[d] = 0; hold[d] = 0; exp_tmo[d] = 0;
         end else if (!en_drv) begin
            armed[d] = 0; exp_tmo[d] = 0;
         end else if (rise_now) begin
            gap = cyc - last_e[d];
            if (armed[d] && gap <= maxp[d]) begin
               hold[d] = gap;
               if (d == 0) exp_q0.push_back({cyc[31:0], gap[31:0]});
               else        exp_q1.push_back({cyc[31:0], gap[31:0]});
            end
            armed[d] = 1; last_e[d] = cyc; exp_tmo[d] = 0;
         end else begin
            exp_tmo[d] = armed[d] && ((cyc - last_e[d]) >= maxp[d]);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic mon(input int d, input logic v, input logic [31:0] p, input logic t);
      logic [63:0] e;
      bool_empty: begin end
      check($sformatf("timeout_%0d", d), {63'd0, t}, {63'd0, exp_tmo[d]});
      check($sformatf("period_hold_%0d", d), {32'd0, p}, hold[d]);
      if (v) begin
         if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            check($sformatf("unexpected_pulse_%0d", d), {63'd0, v}, 64'd0);
         end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("pulse_cycle_%0d", d), cyc, {32'd0, e[63:32]});
            check($sformatf("pulse_period_%0d", d), {32'd0, p}, {32'd0, e[31:0]});
         end
      end else if ((d == 0 && exp_q0.size() != 0) || (d == 1 && exp_q1.size() != 0)) begin
         if (d == 0) e = exp_q0.pop_front();
         else        e = exp_q1.pop_front();
         check($sformatf("missing_pulse_%0d_p%0d", d, e[31:0]), {63'd0, v}, 64'd1);
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus_a.period_valid, bus_a.period, bus_a.timeout);
      mon(1, bus_b.period_valid, {24'd0, bus_b.period}, bus_b.timeout);
   end

   // ---------------- driver tasks ----------------
   // One sig_in cycle of n clk periods: rise on the first cycle. Optionally
   // drops en for three cycles in the middle of the low phase.
   task automatic wave(input int n, input bit drop_en = 1'b0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sig_drv = (i < n / 2);
         if (drop_en && n >= 8 && i == n / 2)     en_drv = 1'b0;
         if (drop_en && n >= 8 && i == n / 2 + 3) en_drv = 1'b1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_period_a"}, {36'd0, bus_a.period}, 64'd0);
      check({tag, "_valid_a"},  {63'd0, bus_a.period_valid}, 64'd0);
      check({tag, "_timeout_a"},{63'd0, bus_a.timeout}, 64'd0);
      check({tag, "_period_b"}, {56'd0, bus_b.period}, 64'd0);
      check({tag, "_timeout_b"},{63'd0, bus_b.timeout}, 64'd0);
      check({tag, "_state_a"},  {62'd0, dbg_a}, {62'd0, IDLE});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1;
      check_outputs_zero("reset");
      repeat (5) @(negedge clk);
      rst_n  = 1'b1;
      en_drv = 1'b1;

      // Square wave, 100-cycle period.
      repeat (6) wave(100);

      // Latency: rise 50 cycles after the previous one, pulse on 3rd edge.
      wave(50);
      @(negedge clk);
      sig_drv = 1'b1;
      @(posedge clk); #1 check("latency_edge1", {63'd0, bus_a.period_valid}, 64'd0);
      @(posedge clk); #1 check("latency_edge2", {63'd0, bus_a.period_valid}, 64'd0);
      @(posedge clk); #1 check("latency_edge3", {63'd0, bus_a.period_valid}, 64'd1);
      check("latency_period", {36'd0, bus_a.period}, 64'd50);
      repeat (30) @(negedge clk);
      sig_drv = 1'b0;
      repeat (20) @(negedge clk);

      // Counter range boundary for the 8-bit meter.
      wave(255); wave(255); wave(256); wave(40); wave(40);
      wave(300); wave(40); wave(40);

      // en dropped mid-count then restored.
      wave(100);
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         sig_drv = (i < 40);
         if (i == 60) en_drv = 1'b0;
         if (i == 75) en_drv = 1'b1;
      end
      wave(70); wave(70); wave(70);

      // en falling in the same cycle the edge is registered.
      wave(60); wave(60);
      @(negedge clk); sig_drv = 1'b1;
      @(negedge clk);
      @(negedge clk); en_drv = 1'b0;
      @(posedge clk); #1;
      check("en_edge_valid_a", {63'd0, bus_a.period_valid}, 64'd0);
      check("en_edge_state_a", {62'd0, dbg_a}, {62'd0, IDLE});
      @(negedge clk); en_drv = 1'b1;
      repeat (20) @(negedge clk);
      sig_drv = 1'b0;
      repeat (10) @(negedge clk);
      wave(60); wave(60); wave(60);

      // Randomized spacings, occasionally with an en glitch.
      for (int k = 0; k < 25; k++) begin
         wave(int'($urandom_range(2, 300)), ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset in the middle of a count.
      wave(90); wave(90);
      @(negedge clk); sig_drv = 1'b1;
      repeat (20) @(negedge clk);
      sig_drv = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("async_rst");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      wave(90); wave(90); wave(90);

      repeat (20) @(negedge clk);
      check("leftover_expected_a", exp_q0.size(), 64'd0);
      check("leftover_expected_b", exp_q1.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/edge_period_meter.md
# edge_period_meter

Measures the period of a slow external or divided-down signal in `clk` cycles. It synchronizes `sig_in`, detects rising edges and counts clock cycles between consecutive edges. It publishes each completed measurement with a one-cycle valid pulse and flags a timeout when no edge arrives within the counter range. It is the consuming end of the board's clock-divider taps: it reads a divider output (e.g. a 28-bit counter MSB) back and reports its period for LED/7-segment display or self-check.

## Interface
Parameters:
- `CNT_W`, 28: period counter width; maximum reportable period is 2^CNT_W−1 cycles.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in` (≥2).

Ports:
- `clk`  input  1  single system clock; all logic is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  measurement enable; low forces IDLE.
- `sig_in`  input  1  asynchronous signal to be measured.
- `period`  output  CNT_W  last completed period in `clk` cycles; held between updates.
- `period_valid`  output  1  one-cycle pulse when `period` is updated.
- `timeout`  output  1  level; high while no edge has been seen for ≥2^CNT_W cycles.

## Operation
- Reset values: `period`=0, `period_valid`=0, `timeout`=0. State is IDLE, the counter is 0 and all synchronizer/edge flops are 0.
- `edge` = synchronized `sig_in` is 1 this cycle and was 0 the previous cycle.
- States: IDLE, MEASURE, TIMEOUT.
- IDLE:
  - `en`=1 and `edge` → MEASURE, cnt←0, no valid pulse. The first edge only starts timing.
- MEASURE:
  - `edge` → `period`←cnt+1, `period_valid`←1, cnt←0, stay in MEASURE.
  - No edge and cnt = 2^CNT_W−2 → TIMEOUT, `timeout`←1, cnt holds.
  - Otherwise cnt←cnt+1.
- TIMEOUT:
  - `edge` → MEASURE, cnt←0, `timeout`←0, no valid pulse, `period` unchanged.
- `en`=0 in any state → IDLE, cnt←0, `timeout`←0. `period` holds and no pulse is issued. `en` low takes priority over a simultaneous edge.
- Width rules: cnt is CNT_W bits and never wraps. The timeout transition precedes the only overflowing value.
- Edges spaced N cycles apart yield `period`=N, with 2 ≤ N ≤ 2^CNT_W−1. N=2 is the minimum detectable spacing after synchronization.
- Reset asserted mid-measurement returns everything to reset values immediately. No partial period is reported.

## Timing
- Latency from a `sig_in` rise to `period_valid`: SYNC_STAGES+1 rising `clk` edges when `sig_in` meets setup before the first edge. That is 3 edges at the default.
- `period_valid` and `period` change on the same clock edge. `period_valid` is high exactly one cycle per completed measurement.
- `timeout` rises 2^CNT_W cycles after the last edge was detected. It falls on the clock edge registering the next detected edge, or on `en`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `epm_pkg`: state enum {IDLE, MEASURE, TIMEOUT} and the default `CNT_W`/`SYNC_STAGES` constants.
- One natural sub-module, `sync_rise_detect`, containing:
  - the SYNC_STAGES flop chain;
  - the previous-value flop;
  - the one-cycle `edge` output.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- Reset release, `en`=1, square wave with rising edges every 100 cycles:
  - no pulse on the first edge;
  - then `period_valid` pulses every 100 cycles with `period`=100;
  - `timeout` stays 0.
- Latency: single `sig_in` rise aligned to a clock edge, with a prior edge 50 cycles earlier → `period_valid` asserts exactly 3 edges later, `period`=50.
- CNT_W=8, edges 255 cycles apart → `period`=255 and no timeout. Edge spacing raised to 256 →
  - `timeout` rises 256 cycles after the last edge, with no pulse;
  - the next edge clears `timeout` without a pulse;
  - the following 40-cycle edge reports `period`=40.
- `en` deasserted mid-count, then reasserted:
  - `period` holds its old value and no pulse is issued;
  - the first edge after re-enable is not reported;
  - the second edge reports the correct spacing.
- `en` falling in the same cycle as `edge` → IDLE, no `period_valid`.
- `rst_n` asserted asynchronously mid-count → all outputs are 0 immediately. After release, the first edge produces no pulse.
